// File: rtl/hlsm_sched_dp.sv
// Seven-step HLSM datapath for the a/b/c -> z/x dataflow.
// Operands are latched on a Start handshake; z and x are published together with a one-cycle Done pulse.
module hlsm_sched_dp #(
  parameter int DW     = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic          Busy,
  output logic          Done,
  output logic [DW-1:0] z,
  output logic [DW-1:0] x
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    S6   = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] ra_r, rb_r, rc_r;
  logic [DW-1:0] d_r, e_r, f_r, g_r, h_r, xi_r;
  logic [DW-1:0] z_r, x_r;
  logic          lt_r, eq_r, busy_r, done_r;
  logic          lt_s;
  logic [DW-1:0] zsh_s;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: only IDLE and DONE look at Start
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) state_s = S1;
        else       state_s = IDLE;
      end
      S1:   state_s = S2;
      S2:   state_s = S3;
      S3:   state_s = S4;
      S4:   state_s = S5;
      S5:   state_s = S6;
      S6:   state_s = DONE;
      DONE: begin
        if (Start) state_s = S1;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Signedness-dependent compare and final shift; if/else keeps the signed shift out of a mixed-sign ?:
  always_comb begin
    lt_s  = 1'b0;
    zsh_s = {DW{1'b0}};
    if (SIGNED) begin
      lt_s  = ($signed(d_r) < $signed(e_r));
      zsh_s = $signed(h_r) >>> eq_r;
    end else begin
      lt_s  = (d_r < e_r);
      zsh_s = h_r >> eq_r;
    end
  end

  // Datapath registers, one scheduled operation group per state
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ra_r   <= {DW{1'b0}};
      rb_r   <= {DW{1'b0}};
      rc_r   <= {DW{1'b0}};
      d_r    <= {DW{1'b0}};
      e_r    <= {DW{1'b0}};
      f_r    <= {DW{1'b0}};
      g_r    <= {DW{1'b0}};
      h_r    <= {DW{1'b0}};
      xi_r   <= {DW{1'b0}};
      lt_r   <= 1'b0;
      eq_r   <= 1'b0;
      z_r    <= {DW{1'b0}};
      x_r    <= {DW{1'b0}};
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= (state_r == S6);
      busy_r <= (state_s != IDLE) && (state_s != DONE);
      case (state_r)
        IDLE, DONE: begin
          if (Start) begin
            ra_r <= a;
            rb_r <= b;
            rc_r <= c;
          end
        end
        S1: d_r <= ra_r + rb_r;
        S2: e_r <= ra_r + rc_r;
        S3: lt_r <= lt_s;
        S4: begin
          eq_r <= (d_r == e_r);
          f_r  <= ra_r - rb_r;
          g_r  <= (d_r != {DW{1'b0}}) ? e_r : {{(DW-1){1'b0}}, lt_r};
        end
        S5: begin
          h_r  <= (g_r != {DW{1'b0}}) ? f_r : {{(DW-1){1'b0}}, eq_r};
          xi_r <= g_r << lt_r;
        end
        S6: begin
          z_r <= zsh_s;
          x_r <= xi_r;
        end
        default: begin
          d_r <= d_r;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign z    = z_r;
  assign x    = x_r;

endmodule

// File: tb/tb_hlsm_sched_dp.sv
// Scoreboard bench: three configurations (32/signed, 8/unsigned, 8/signed) share stimulus;
// expected results and due cycles are queued at issue and popped by a monitor on Done.
module tb_hlsm_sched_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  st;
  logic [31:0] a, b, c;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  logic        by0, by1, by2, dn0, dn1, dn2;
  logic [31:0] z0, x0;
  logic [7:0]  z1, x1, z2, x2;
  logic [31:0] zv [3];
  logic [31:0] xv [3];
  logic        dv [3];
  logic [31:0] lz [3];
  logic [31:0] lx [3];

  typedef struct {
    int          inst;
    logic [31:0] z;
    logic [31:0] x;
    int          due;
  } exp_t;
  exp_t q[$];

  hlsm_sched_dp #(.DW(32), .SIGNED(1'b1)) u0 (
    .Clk(clk), .Rst(rst), .Start(st[0]), .a(a), .b(b), .c(c),
    .Busy(by0), .Done(dn0), .z(z0), .x(x0));
  hlsm_sched_dp #(.DW(8), .SIGNED(1'b0)) u1 (
    .Clk(clk), .Rst(rst), .Start(st[1]), .a(a[7:0]), .b(b[7:0]), .c(c[7:0]),
    .Busy(by1), .Done(dn1), .z(z1), .x(x1));
  hlsm_sched_dp #(.DW(8), .SIGNED(1'b1)) u2 (
    .Clk(clk), .Rst(rst), .Start(st[2]), .a(a[7:0]), .b(b[7:0]), .c(c[7:0]),
    .Busy(by2), .Done(dn2), .z(z2), .x(x2));

  assign zv[0] = z0;
  assign xv[0] = x0;
  assign dv[0] = dn0;
  assign zv[1] = {24'd0, z1};
  assign xv[1] = {24'd0, x1};
  assign dv[1] = dn1;
  assign zv[2] = {24'd0, z2};
  assign xv[2] = {24'd0, x2};
  assign dv[2] = dn2;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: reset clearing, Done scoreboard, and z/x hold between completions
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        chk($sformatf("rst_clear%0d", i), {31'd0, dv[i]} | zv[i] | xv[i], 32'd0);
        lz[i] = 32'd0;
        lx[i] = 32'd0;
      end else if (dv[i]) begin
        if (q.size() == 0) begin
          chk($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_inst", i, e.inst);
          chk("done_cycle", cyc, e.due);
          chk($sformatf("z%0d", i), zv[i], e.z);
          chk($sformatf("x%0d", i), xv[i], e.x);
        end
        lz[i] = zv[i];
        lx[i] = xv[i];
      end else begin
        chk($sformatf("hold%0d", i), {zv[i] ^ lz[i]} | {xv[i] ^ lx[i]}, 32'd0);
      end
    end
  end

  task automatic slot();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int lim);
    int k = 0;
    while (q.size() != 0 && k < lim) begin
      slot();
      k++;
    end
    chk("drain", q.size(), 32'd0);
    q.delete();
  endtask

  task automatic run(input int i, input logic [31:0] av, bv, cv, ez, ex);
    slot();
    a = av; b = bv; c = cv;
    st[i] = 1'b1;
    q.push_back('{i, ez, ex, cyc + 7});
    slot();
    st[i] = 1'b0;
    a = ~av; b = bv ^ 32'h5A5A5A5A; c = cv + 32'd77;
    wait_drain(12);
    slot();
  endtask

  initial begin
    rst = 1'b1;
    st = 3'b000;
    a = 32'd0; b = 32'd0; c = 32'd0;
    repeat (3) slot();
    rst = 1'b0;
    slot();
    chk("reset_busy", {29'd0, by0, by1, by2}, 32'd0);

    // Basic run with Busy profile: six cycles high, low in the Done cycle
    a = 32'd5; b = 32'd3; c = 32'd10;
    st[0] = 1'b1;
    q.push_back('{0, 32'd2, 32'd30, cyc + 7});
    for (int k = 1; k <= 7; k++) begin
      slot();
      st[0] = 1'b0;
      a = 32'hDEAD0000 + k;
      chk($sformatf("busy_k%0d", k), {31'd0, by0}, (k <= 6) ? 32'd1 : 32'd0);
    end
    wait_drain(12);
    repeat (3) slot();

    run(0, 32'd4, 32'd4, 32'd4, 32'd0, 32'd8);
    run(0, 32'd0, 32'd0, 32'd7, 32'd0, 32'd2);
    run(0, 32'hFFFFFFF8, 32'd0, 32'd0, 32'hFFFFFFFC, 32'hFFFFFFF8);
    run(1, 32'h000000F8, 32'd0, 32'd0, 32'h0000007C, 32'h000000F8);
    run(2, 32'd127, 32'd1, 32'd0, 32'd126, 32'h000000FE);

    // Start re-pulsed in S3 must be ignored
    slot();
    a = 32'd4; b = 32'd4; c = 32'd4;
    st[0] = 1'b1;
    q.push_back('{0, 32'd0, 32'd8, cyc + 7});
    slot(); st[0] = 1'b0;
    slot(); st[0] = 1'b1;
    slot(); st[0] = 1'b0;
    wait_drain(12);
    repeat (10) slot();

    // Back-to-back: Start held through DONE, second operands set while busy
    slot();
    a = 32'd5; b = 32'd3; c = 32'd10;
    st[0] = 1'b1;
    q.push_back('{0, 32'd2, 32'd30, cyc + 7});
    q.push_back('{0, 32'd0, 32'd8, cyc + 14});
    slot();
    a = 32'd4; b = 32'd4; c = 32'd4;
    repeat (7) slot();
    st[0] = 1'b0;
    a = 32'd99; b = 32'd1; c = 32'd2;
    wait_drain(20);
    repeat (3) slot();

    // Establish nonzero z/x, then reset in S4
    run(0, 32'd5, 32'd3, 32'd10, 32'd2, 32'd30);
    a = 32'd5; b = 32'd3; c = 32'd10;
    st[0] = 1'b1;
    slot(); st[0] = 1'b0;
    slot();
    slot();
    rst = 1'b1;
    slot();
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, by0}, 32'd0);
    chk("rst_mid_z", z0, 32'd0);
    repeat (10) slot();

    // Rst wins over Start in IDLE
    rst = 1'b1;
    st[0] = 1'b1;
    slot();
    rst = 1'b0;
    st[0] = 1'b0;
    chk("rst_start_busy_a", {31'd0, by0}, 32'd0);
    slot();
    chk("rst_start_busy_b", {31'd0, by0}, 32'd0);
    repeat (10) slot();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
